// File: rtl/dsp_ctrl_pkg.sv
// Shared types and helpers for the DSP MAC job sequencer.
package dsp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] MODE_SMALL   = 2'b00;
  localparam logic [1:0] MODE_MIXED   = 2'b01;
  localparam logic [1:0] MODE_FULL    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // A job is runnable only with a real mode, at least one pair, and a latency the DSP supports.
  function automatic logic cfg_legal(input logic [1:0] mode, input int unsigned len,
                                     input int unsigned pipe, input int unsigned max_pipe);
    return (mode != MODE_ILLEGAL) && (len != 0) && (pipe <= max_pipe);
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Host-side job bus: configuration, operand stream and result handshakes.
interface dsp_mac_sequencer_if #(
  parameter int WIDTH         = 16,
  parameter int SHIFT_BITS    = 2,
  parameter int PIPELINE_BITS = 3,
  parameter int LEN_BITS      = 8
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_mode;
  logic [LEN_BITS-1:0]      cfg_len;
  logic [SHIFT_BITS-1:0]    cfg_shift_amount;
  logic                     cfg_shift_dir;
  logic [PIPELINE_BITS-1:0] cfg_pipe_stages;
  logic [2*WIDTH-1:0]       cfg_cc;
  logic                     op_valid;
  logic                     op_ready;
  logic [WIDTH-1:0]         op_a;
  logic [WIDTH-1:0]         op_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [2*WIDTH-1:0]       res_data;
  logic                     res_err;

  modport master (
    output cfg_valid, cfg_mode, cfg_len, cfg_shift_amount, cfg_shift_dir,
           cfg_pipe_stages, cfg_cc, op_valid, op_a, op_b, res_ready,
    input  cfg_ready, op_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_len, cfg_shift_amount, cfg_shift_dir,
           cfg_pipe_stages, cfg_cc, op_valid, op_a, op_b, res_ready,
    output cfg_ready, op_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/dsp_latency_counter.sv
// Down-counter that marks the cycle in which the DSP output pipeline has delivered the final sum.
module dsp_latency_counter #(
  parameter int CNT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  input  logic                dec,
  output logic [CNT_BITS-1:0] count,
  output logic                done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The edge ending the cycle with count == 1 is the edge at which dsp_out is valid.
  assign done = dec && (count == CNT_BITS'(1));

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one MAC DSP through an N-term dot product and returns the final accumulator.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SHIFT_BITS    = 2,
  parameter int PIPELINE_BITS = 3,
  parameter int LEN_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dsp_mac_sequencer_if.slave       bus,
  output logic                     busy,
  output logic                     dsp_start,
  output logic                     dsp_mac,
  output logic                     dsp_shift_dir,
  output logic [1:0]               dsp_mode,
  output logic [SHIFT_BITS-1:0]    dsp_shift_amount,
  output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
  output logic [WIDTH-1:0]         dsp_aa,
  output logic [WIDTH-1:0]         dsp_bb,
  output logic [2*WIDTH-1:0]       dsp_cc,
  input  logic [2*WIDTH-1:0]       dsp_out
);

  seq_state_t               state_reg, state_next;
  logic [1:0]               mode_reg;
  logic [SHIFT_BITS-1:0]    shift_amount_reg;
  logic                     shift_dir_reg;
  logic [PIPELINE_BITS-1:0] pipe_reg;
  logic [2*WIDTH-1:0]       cc_reg;
  logic [LEN_BITS-1:0]      remain_reg;
  logic                     err_reg;
  logic                     used_reg;
  logic [2*WIDTH-1:0]       res_data_reg;

  logic                     cfg_ok;
  logic                     last_issue;
  logic                     drain_load;
  logic                     drain_done;
  logic [PIPELINE_BITS-1:0] drain_count;

  assign cfg_ok     = cfg_legal(bus.cfg_mode, 32'(bus.cfg_len), 32'(bus.cfg_pipe_stages),
                                PIPELINE_BITS);
  assign last_issue = (state_reg == ST_ISSUE) && bus.op_valid && (remain_reg == LEN_BITS'(1));
  assign drain_load = last_issue && (pipe_reg != '0);

  dsp_latency_counter #(.CNT_BITS(PIPELINE_BITS)) u_drain (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (pipe_reg),
    .dec      (state_reg == ST_DRAIN),
    .count    (drain_count),
    .done     (drain_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      mode_reg         <= '0;
      shift_amount_reg <= '0;
      shift_dir_reg    <= 1'b0;
      pipe_reg         <= '0;
      cc_reg           <= '0;
      remain_reg       <= '0;
      err_reg          <= 1'b0;
      used_reg         <= 1'b0;
      res_data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (bus.cfg_valid) begin
            mode_reg         <= bus.cfg_mode;
            shift_amount_reg <= bus.cfg_shift_amount;
            shift_dir_reg    <= bus.cfg_shift_dir;
            pipe_reg         <= bus.cfg_pipe_stages;
            cc_reg           <= bus.cfg_cc;
            remain_reg       <= bus.cfg_len;
            err_reg          <= !cfg_ok;
            used_reg         <= cfg_ok;
            // A rejected job reports its addend untouched.
            if (!cfg_ok) res_data_reg <= bus.cfg_cc;
          end
        end
        ST_ISSUE: begin
          if (bus.op_valid) begin
            remain_reg <= remain_reg - 1'b1;
            if (last_issue && (pipe_reg == '0)) res_data_reg <= dsp_out;
          end else if (mode_reg == MODE_SMALL) begin
            // Small mode loses its running sum on a gap, so the job can no longer be trusted.
            err_reg <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) res_data_reg <= dsp_out;
        end
        ST_DONE: begin
          if (bus.res_ready) used_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.cfg_valid) state_next = cfg_ok ? ST_SETUP : ST_DONE;
      ST_SETUP: state_next = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_next = (pipe_reg == '0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready    = (state_reg == ST_IDLE);
    bus.op_ready     = (state_reg == ST_ISSUE);
    bus.res_valid    = (state_reg == ST_DONE);
    bus.res_data     = res_data_reg;
    bus.res_err      = err_reg;
    busy             = (state_reg != ST_IDLE);
    dsp_start        = 1'b0;
    dsp_mac          = 1'b0;
    dsp_mode         = '0;
    dsp_shift_amount = '0;
    dsp_shift_dir    = 1'b0;
    dsp_pipe_stages  = '0;
    dsp_cc           = '0;
    dsp_aa           = '0;
    dsp_bb           = '0;
    if ((state_reg == ST_SETUP) || (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN)) begin
      dsp_mode         = mode_reg;
      dsp_shift_amount = shift_amount_reg;
      dsp_shift_dir    = shift_dir_reg;
      dsp_pipe_stages  = pipe_reg;
      dsp_cc           = cc_reg;
    end
    case (state_reg)
      ST_ISSUE: begin
        dsp_mac   = 1'b1;
        dsp_start = bus.op_valid;
        dsp_aa    = bus.op_a;
        dsp_bb    = bus.op_b;
      end
      ST_DRAIN: dsp_mac = 1'b1;
      ST_DONE:  dsp_mac = used_reg;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer driving a behavioural MAC DSP with programmable latency.
module tb_dsp_mac_sequencer;
  import dsp_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int SB = 2;
  localparam int PB = 3;
  localparam int LB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.WIDTH(W), .SHIFT_BITS(SB), .PIPELINE_BITS(PB), .LEN_BITS(LB)) bus ();

  logic          busy, dsp_start, dsp_mac, dsp_shift_dir;
  logic [1:0]    dsp_mode;
  logic [SB-1:0] dsp_shift_amount;
  logic [PB-1:0] dsp_pipe_stages;
  logic [W-1:0]  dsp_aa, dsp_bb;
  logic [2*W-1:0] dsp_cc, dsp_out;

  dsp_mac_sequencer #(.WIDTH(W), .SHIFT_BITS(SB), .PIPELINE_BITS(PB), .LEN_BITS(LB)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .busy             (busy),
    .dsp_start        (dsp_start),
    .dsp_mac          (dsp_mac),
    .dsp_shift_dir    (dsp_shift_dir),
    .dsp_mode         (dsp_mode),
    .dsp_shift_amount (dsp_shift_amount),
    .dsp_pipe_stages  (dsp_pipe_stages),
    .dsp_aa           (dsp_aa),
    .dsp_bb           (dsp_bb),
    .dsp_cc           (dsp_cc),
    .dsp_out          (dsp_out)
  );

  // Behavioural DSP: registered sum and mac_prev, output delayed by pipe_stages (0 = combinational).
  logic signed [2*W-1:0] sum_reg, next_sum, addend, shifted, prod;
  logic                  mac_prev;
  logic signed [2*W-1:0] pipe_q [1:7];

  always_comb begin
    shifted = dsp_shift_dir ? (sum_reg >>> dsp_shift_amount) : (sum_reg << dsp_shift_amount);
    addend  = mac_prev ? shifted : $signed(dsp_cc);
    prod    = $signed(dsp_aa) * $signed(dsp_bb);
    if (dsp_start)                              next_sum = prod + addend;
    else if (dsp_mac && dsp_mode == MODE_SMALL) next_sum = '0;
    else                                        next_sum = sum_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= '0;
      mac_prev <= 1'b0;
      for (int k = 1; k < 8; k++) pipe_q[k] <= '0;
    end else begin
      sum_reg   <= next_sum;
      mac_prev  <= dsp_mac;
      pipe_q[1] <= next_sum;
      for (int k = 2; k < 8; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign dsp_out = (dsp_pipe_stages == '0) ? next_sum : pipe_q[dsp_pipe_stages];

  typedef struct {
    logic [2*W-1:0] data;
    logic           err;
    int             lat;
    int             starts;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor samples 2ns after each falling edge, when stimulus has settled for the coming rising edge.
  int             cyc = 0, last_ev = 0, first_cyc = 0, starts = 0, cfg_cyc = -10, jobno = 0;
  logic           setup_mac = 1'b0, prev_valid = 1'b0, unstable = 1'b0, snap_err = 1'b0;
  logic [2*W-1:0] snap_data = '0;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (cyc == cfg_cyc + 1) setup_mac = dsp_mac;
      if (bus.cfg_valid && bus.cfg_ready) begin
        last_ev = cyc;
        cfg_cyc = cyc;
        starts  = 0;
      end
      if (bus.op_valid && bus.op_ready) last_ev = cyc;
      if (dsp_start) starts++;
      if (bus.res_valid) begin
        if (!prev_valid) begin
          first_cyc = cyc;
          snap_data = bus.res_data;
          snap_err  = bus.res_err;
          unstable  = 1'b0;
        end else if (bus.res_data != snap_data || bus.res_err != snap_err) begin
          unstable = 1'b1;
        end
        if (bus.cfg_ready) unstable = 1'b1;
        if (bus.res_ready) begin
          jobno++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL job%0d unexpected result got %0d want none", jobno, bus.res_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("job%0d data", jobno), int'(bus.res_data), int'(e.data));
            chk($sformatf("job%0d err", jobno), int'(bus.res_err), int'(e.err));
            chk($sformatf("job%0d latency", jobno), first_cyc - last_ev, e.lat);
            chk($sformatf("job%0d dsp_starts", jobno), starts, e.starts);
            chk($sformatf("job%0d setup_mac", jobno), int'(setup_mac), 0);
            chk($sformatf("job%0d hold_stable", jobno), int'(unstable), 0);
            $display("job%0d result data=%0d err=%0d latency=%0d starts=%0d", jobno,
                     $signed(bus.res_data), bus.res_err, first_cyc - last_ev, starts);
          end
        end
      end
      prev_valid = bus.res_valid && !bus.res_ready;
    end
  end

  task automatic push_exp(input int data, input logic err, input int lat, input int st);
    exp_t e;
    e.data   = 32'(data);
    e.err    = err;
    e.lat    = lat;
    e.starts = st;
    sb_q.push_back(e);
  endtask

  task automatic send_cfg(input logic [1:0] mode, input int len, input int sh, input logic dir,
                          input int pipe, input int cc);
    bus.cfg_mode         = mode;
    bus.cfg_len          = LB'(len);
    bus.cfg_shift_amount = SB'(sh);
    bus.cfg_shift_dir    = dir;
    bus.cfg_pipe_stages  = PB'(pipe);
    bus.cfg_cc           = 32'(cc);
    bus.cfg_valid        = 1'b1;
    while (!bus.cfg_ready) @(negedge clk);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_op(input int a, input int b);
    bus.op_a     = W'(a);
    bus.op_b     = W'(b);
    bus.op_valid = 1'b1;
    while (!bus.op_ready) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic op_idle();
    bus.op_valid = 1'b0;
  endtask

  task automatic drain_sb();
    while (sb_q.size() != 0) @(negedge clk);
  endtask

  initial begin
    #50000;
    checks++;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_mode = '0; bus.cfg_len = '0; bus.cfg_shift_amount = '0;
    bus.cfg_shift_dir = 1'b0; bus.cfg_pipe_stages = '0; bus.cfg_cc = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset cfg_ready", int'(bus.cfg_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset res_valid", int'(bus.res_valid), 0);
    chk("reset res_data", int'(bus.res_data), 0);
    chk("reset dsp_mac", int'(dsp_mac), 0);
    chk("reset op_ready", int'(bus.op_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // 10 + 10 + 18 - 28 = 10, pipe 0
    push_exp(10, 1'b0, 1, 3);
    send_cfg(MODE_FULL, 3, 0, 1'b0, 0, 10);
    send_op(2, 5); send_op(3, 6); send_op(-4, 7); op_idle();

    // 9, then 4 + (9 >>> 1) = 8, pipe 2
    push_exp(8, 1'b0, 3, 2);
    send_cfg(MODE_SMALL, 2, 1, 1'b1, 2, 0);
    send_op(3, 3); send_op(2, 2); op_idle();

    // mixed mode holds its sum across a gap: 300
    push_exp(300, 1'b0, 2, 3);
    send_cfg(MODE_MIXED, 3, 0, 1'b0, 1, 0);
    send_op(1, 100); op_idle(); @(negedge clk);
    send_op(1, 100); send_op(1, 100); op_idle();

    // small mode clears on the gap: 100, 0, 100, 200 with error
    push_exp(200, 1'b1, 1, 3);
    send_cfg(MODE_SMALL, 3, 0, 1'b0, 0, 0);
    send_op(1, 100); op_idle(); @(negedge clk);
    send_op(1, 100); send_op(1, 100); op_idle();

    // rejected jobs: illegal mode, latency too deep, zero length
    push_exp(7, 1'b1, 1, 0);
    send_cfg(MODE_ILLEGAL, 3, 0, 1'b0, 0, 7);
    push_exp(7, 1'b1, 1, 0);
    send_cfg(MODE_FULL, 3, 0, 1'b0, 5, 7);
    push_exp(7, 1'b1, 1, 0);
    send_cfg(MODE_FULL, 0, 0, 1'b0, 0, 7);
    drain_sb();

    // -5 + 16 = 11, then -3 + (11 << 1) = 19, pipe 3, result held while res_ready low
    bus.res_ready = 1'b0;
    push_exp(19, 1'b0, 4, 2);
    send_cfg(MODE_FULL, 2, 1, 1'b0, 3, -5);
    send_op(4, 4); send_op(1, -3); op_idle();
    while (!bus.res_valid) @(negedge clk);
    repeat (5) @(negedge clk);

    // back-to-back job: -21 + 1000 = 979
    bus.res_ready = 1'b1;
    push_exp(979, 1'b0, 1, 1);
    send_cfg(MODE_MIXED, 1, 0, 1'b0, 0, 1000);
    send_op(-7, 3); op_idle();
    drain_sb();

    // reset in the middle of issue
    send_cfg(MODE_FULL, 4, 0, 1'b0, 1, 0);
    send_op(1, 1); send_op(2, 2); op_idle();
    #3 rst = 1'b1;
    #1;
    chk("midrst cfg_ready", int'(bus.cfg_ready), 1);
    chk("midrst busy", int'(busy), 0);
    chk("midrst op_ready", int'(bus.op_ready), 0);
    chk("midrst dsp_mac", int'(dsp_mac), 0);
    chk("midrst dsp_mode", int'(dsp_mode), 0);
    chk("midrst res_data", int'(bus.res_data), 0);
    chk("midrst res_valid", int'(bus.res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 4 + 3 = 7, then 1 + 7 = 8
    push_exp(8, 1'b0, 2, 2);
    send_cfg(MODE_FULL, 2, 0, 1'b0, 1, 3);
    send_op(2, 2); send_op(1, 1); op_idle();
    drain_sb();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
